pipelined_mac: RTL

- Parametrised successor to the 16-bit signed pipelined multiplier: a 3-stage multiply-accumulate unit.
- Generalisations: per-operand width, runtime signed/unsigned mode, load/accumulate control, optional saturation, sticky overflow flag, valid/ready flow control with backpressure.
- Sits between the circuit-solver datapath (operand producers) and result consumers (accumulating dot products of matrix rows).

---
 rtl/mac_pkg.sv | 20 ++
 rtl/mac_sat_add.sv | 38 +++
 rtl/pipelined_mac.sv | 89 ++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared constants and clamp-limit helpers for the pipelined MAC
package mac_pkg;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;
  localparam logic ACC_LOAD      = 1'b0;
  localparam logic ACC_ADD       = 1'b1;

  // Helpers return a wide value; callers keep the low n bits.
  localparam int MAX_W = 128;

  function automatic logic [MAX_W-1:0] signed_max(input int n);
    return (MAX_W'(1) << (n - 1)) - MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] signed_min(input int n);
    return MAX_W'(1) << (n - 1);
  endfunction

endpackage

// File: rtl/mac_sat_add.sv
// rtl/mac_sat_add.sv - accumulator adder with signed/unsigned overflow detect and optional clamp
module mac_sat_add
  import mac_pkg::*;
#(
  parameter int WIDTH    = 40,
  parameter bit SATURATE = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  localparam logic [MAX_W-1:0] SMAX_FULL = signed_max(WIDTH);
  localparam logic [MAX_W-1:0] SMIN_FULL = signed_min(WIDTH);
  localparam logic [WIDTH-1:0] SMAX = SMAX_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SMIN = SMIN_FULL[WIDTH-1:0];

  logic [WIDTH:0]   full;
  logic [WIDTH-1:0] wrapped;
  logic             sovf;

  assign full    = {1'b0, a} + {1'b0, b};
  assign wrapped = full[WIDTH-1:0];
  assign sovf    = (a[WIDTH-1] == b[WIDTH-1]) && (wrapped[WIDTH-1] != a[WIDTH-1]);
  assign ovf     = (signed_mode == MODE_SIGNED) ? sovf : full[WIDTH];

  // Signed overflow direction follows the (shared) operand sign.
  always_comb begin
    sum = wrapped;
    if (SATURATE && ovf) begin
      if (signed_mode == MODE_SIGNED) sum = a[WIDTH-1] ? SMIN : SMAX;
      else                            sum = '1;
    end
  end

endmodule

// File: rtl/pipelined_mac.sv
// rtl/pipelined_mac.sv - 3-stage multiply-accumulate with signed/unsigned mode and backpressure
module pipelined_mac
  import mac_pkg::*;
#(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int ACC_WIDTH = 40,
  parameter bit SATURATE  = 1'b0
) (
  input  logic                 clock,
  input  logic                 aclr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   dataa,
  input  logic [B_WIDTH-1:0]   datab,
  input  logic                 signed_mode,
  input  logic                 acc_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 overflow
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;

  logic                 adv;
  logic [A_WIDTH-1:0]   a1;
  logic [B_WIDTH-1:0]   b1;
  logic                 sm1, ae1, v1;
  logic [P_WIDTH-1:0]   ax, bx, prod;
  logic [P_WIDTH-1:0]   p2;
  logic                 sm2, ae2, v2;
  logic [ACC_WIDTH-1:0] ext, acc, sum;
  logic                 ovf;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign result   = acc;

  // Extending to the product width makes one modulo multiplier serve both modes.
  assign ax   = {{B_WIDTH{sm1 & a1[A_WIDTH-1]}}, a1};
  assign bx   = {{A_WIDTH{sm1 & b1[B_WIDTH-1]}}, b1};
  assign prod = ax * bx;

  always_comb begin
    ext = {ACC_WIDTH{sm2 & p2[P_WIDTH-1]}};
    ext[P_WIDTH-1:0] = p2;
  end

  mac_sat_add #(
    .WIDTH   (ACC_WIDTH),
    .SATURATE(SATURATE)
  ) u_add (
    .a          (acc),
    .b          (ext),
    .signed_mode(sm2),
    .sum        (sum),
    .ovf        (ovf)
  );

  always_ff @(posedge clock) begin
    if (aclr) begin
      a1 <= '0; b1 <= '0; sm1 <= 1'b0; ae1 <= 1'b0; v1 <= 1'b0;
      p2 <= '0; sm2 <= 1'b0; ae2 <= 1'b0; v2 <= 1'b0;
      acc <= '0; overflow <= 1'b0; out_valid <= 1'b0;
    end else if (adv) begin
      v1  <= in_valid;
      a1  <= dataa;
      b1  <= datab;
      sm1 <= signed_mode;
      ae1 <= acc_en;
      v2  <= v1;
      p2  <= prod;
      sm2 <= sm1;
      ae2 <= ae1;
      out_valid <= v2;
      if (v2) begin
        if (ae2 == ACC_ADD) begin
          acc      <= sum;
          overflow <= overflow | ovf;
        end else begin
          acc      <= ext;
          overflow <= 1'b0;
        end
      end
    end
  end

endmodule
